reg_file_2r1w: RTL and testbench



---
 rtl/reg_file_2r1w.sv | 127 ++++++++++++
 tb/tb_reg_file_2r1w.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// -----------------------------------------------------------------------------
// reg_file_2r1w
//
// Purpose:
//   Decode-stage register file: DEPTH = 2**ADDR_WIDTH words of DATA_WIDTH bits.
//   It has two combinational read ports and one synchronous write port.
//   Register ZERO_IDX is hardwired to zero (XZR): writes to it are discarded
//   and reads of it always return 0. A saturating counter tracks committed
//   writes.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When the macro is defined, a committed write is forwarded combinationally
//   to any read port that addresses the same register in the same cycle
//   (write-first). When it is undefined, a same-cycle read returns the stored
//   (old) value.
//
// Ports:
//   clk       in   1           clock, all state updates on rising edge
//   rst       in   1           synchronous active-high reset (priority over we)
//   we        in   1           write enable
//   wa        in   ADDR_WIDTH  write address
//   wd        in   DATA_WIDTH  write data
//   ra1       in   ADDR_WIDTH  read address, port 1
//   ra2       in   ADDR_WIDTH  read address, port 2
//   rd1       out  DATA_WIDTH  read data, port 1 (combinational)
//   rd2       out  DATA_WIDTH  read data, port 2 (combinational)
//   wr_count  out  16          committed-write count, saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module reg_file_2r1w #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_IDX   = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  output logic [15:0]           wr_count
);

  localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_IDX);
  localparam logic [15:0]         COUNT_MAX = 16'hFFFF;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [15:0]           wr_count_q;
  logic [15:0]           wr_count_d;
  logic                  commit_s;

  // A write only takes effect outside reset and when it does not target XZR.
  assign commit_s = we && !rst && (wa != ZERO_ADDR);

  // Storage array: cleared by reset, otherwise updated by committed writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit_s) begin
      mem_q[wa] <= wd;
    end else begin
      mem_q[wa] <= mem_q[wa];
    end
  end

  // Next value of the committed-write counter; holds once it saturates.
  always_comb begin
    wr_count_d = wr_count_q;
    if (commit_s && (wr_count_q != COUNT_MAX)) begin
      wr_count_d = wr_count_q + 16'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // Committed-write counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= 16'd0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;

  // Read port 1: stored value, optional write-first forward, XZR forced to 0.
  always_comb begin
    rd1 = mem_q[ra1];
`ifdef REGFILE_BYPASS_EN
    if (commit_s && (ra1 == wa)) begin
      rd1 = wd;
    end else begin
      rd1 = mem_q[ra1];
    end
`endif
    // The zero check comes last so that it also overrides the forward path.
    if (ra1 == ZERO_ADDR) begin
      rd1 = '0;
    end else begin
      rd1 = rd1;
    end
  end

  // Read port 2: same structure as port 1, evaluated independently.
  always_comb begin
    rd2 = mem_q[ra2];
`ifdef REGFILE_BYPASS_EN
    if (commit_s && (ra2 == wa)) begin
      rd2 = wd;
    end else begin
      rd2 = mem_q[ra2];
    end
`endif
    if (ra2 == ZERO_ADDR) begin
      rd2 = '0;
    end else begin
      rd2 = rd2;
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// -----------------------------------------------------------------------------
// tb_reg_file_2r1w
//
// Self-checking bench for reg_file_2r1w. A reference model (an array of words
// plus an integer write count) predicts every read and the write counter.
// Directed scenarios and randomized traffic are applied one clock at a time.
// Honours REGFILE_BYPASS_EN in the same way as the design build.
// -----------------------------------------------------------------------------
module tb_reg_file_2r1w;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [63:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [63:0] rd1;
  logic [63:0] rd2;
  logic [15:0] wr_count;

  int tests_run;
  int tests_failed;

  // Reference model
  logic [63:0] model_mem [32];
  int          model_count;

  reg_file_2r1w #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(5),
    .ZERO_IDX  (31)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .ra1     (ra1),
    .ra2     (ra2),
    .rd1     (rd1),
    .rd2     (rd2),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value a read port must show, from the current inputs and model state.
  function automatic logic [63:0] expect_rd(input logic [4:0] ra);
    if (ra == 5'd31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && !rst && (wa != 5'd31) && (ra == wa)) return wd;
`endif
    return model_mem[ra];
  endfunction

  // One clock: drive inputs, check reads before the edge, update model,
  // check counter after the edge.
  task automatic cycle(input logic r, input logic w, input logic [4:0] a,
                       input logic [63:0] d, input logic [4:0] a1,
                       input logic [4:0] a2, input bit chk_rd, input string tag);
    rst = r; we = w; wa = a; wd = d; ra1 = a1; ra2 = a2;
    #1;
    if (chk_rd) begin
      check({tag, ".rd1"}, rd1, expect_rd(a1));
      check({tag, ".rd2"}, rd2, expect_rd(a2));
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model_mem[i] = 64'd0;
      model_count = 0;
    end else if (w && (a != 5'd31)) begin
      model_mem[a] = d;
      if (model_count < 65535) model_count++;
    end
    #1;
    check({tag, ".wr_count"}, {48'd0, wr_count}, 64'(model_count));
  endtask

  initial begin
    logic [63:0] rnd;
    logic [63:0] last_wd;
    logic [4:0]  a;
    tests_run = 0;
    tests_failed = 0;
    model_count = 0;
    for (int i = 0; i < 32; i++) model_mem[i] = 64'd0;
    rst = 1'b1; we = 1'b0; wa = 5'd0; wd = 64'd0; ra1 = 5'd0; ra2 = 5'd0;

    // Initial reset; storage contents are unknown before it.
    cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0, "init_rst");

    // 1. Random writes, then reset, then sweep every address.
    for (int i = 0; i < 40; i++) begin
      rnd = {$urandom, $urandom};
      cycle(1'b0, 1'b1, 5'($urandom_range(0, 31)), rnd,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1, "pre_rst");
    end
    cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b1, "mid_rst");
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i), 1'b1, "sweep");
      check("sweep.zero", rd1, 64'd0);
    end

    // 2. Basic write then read on both ports.
    cycle(1'b0, 1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 5'd0, 5'd0, 1'b1, "wr5");
    cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5, 1'b1, "rd5");
    check("rd5.rd1", rd1, 64'hDEADBEEF_CAFEF00D);
    check("rd5.rd2", rd2, 64'hDEADBEEF_CAFEF00D);
    check("rd5.cnt", {48'd0, wr_count}, 64'd1);

    // 3. Write to XZR is ignored and does not count.
    cycle(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 1'b1, "wr31");
    cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'd31, 5'd5, 1'b1, "rd31");
    check("rd31.rd1", rd1, 64'd0);
    check("rd31.cnt", {48'd0, wr_count}, 64'd1);

    // 4. Same-cycle read/write of one register.
    cycle(1'b0, 1'b1, 5'd7, 64'h1, 5'd0, 5'd0, 1'b1, "wr7a");
    we = 1'b1; wa = 5'd7; wd = 64'h2; ra1 = 5'd7; rst = 1'b0;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle.rd1", rd1, 64'h2);
`else
    check("same_cycle.rd1", rd1, 64'h1);
`endif
    cycle(1'b0, 1'b1, 5'd7, 64'h2, 5'd7, 5'd7, 1'b1, "wr7b");
    cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd31, 1'b1, "rd7");
    check("rd7.rd1", rd1, 64'h2);

    // 5. Reset wins over a simultaneous write.
    cycle(1'b1, 1'b1, 5'd3, 64'hA5, 5'd3, 5'd3, 1'b1, "rst_we");
    cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd7, 1'b1, "rd3");
    check("rd3.rd1", rd1, 64'd0);
    check("rd3.cnt", {48'd0, wr_count}, 64'd0);

    // Randomized traffic with occasional resets and forced read/write overlap.
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom};
      a = 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), a, rnd,
            ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)),
            1'b1, "rand");
    end

    // 6. Counter saturation: 65540 writes to register 1 after a reset.
    cycle(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b1, "sat_rst");
    last_wd = 64'd0;
    for (int i = 0; i < 65540; i++) begin
      last_wd = {$urandom, $urandom};
      cycle(1'b0, 1'b1, 5'd1, last_wd, 5'd1, 5'd2, (i % 1024) == 0, "sat");
    end
    cycle(1'b0, 1'b0, 5'd0, 64'd0, 5'd1, 5'd1, 1'b1, "sat_rd");
    check("sat.cnt", {48'd0, wr_count}, 64'h0000_0000_0000_FFFF);
    check("sat.mem1", rd1, last_wd);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
